// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Multi-port register file with a per-register busy scoreboard for the
// pipelined MIPS datapath. It replaces the older two-read/one-write file.
//
//   * NRD combinational read ports.
//   * Two write ports. When both target the same register, port 1 wins.
//   * One busy bit per register. A reservation sets the bit and a write-back
//     clears it. When both happen to the same register in one cycle, the
//     reservation wins, so a newer producer keeps the register busy.
//   * A registered count of busy registers, kept up to date incrementally.
//
// Optional feature, macro REGFILE_BYPASS_EN:
//   This macro enables write-first forwarding from the write ports to the read
//   ports. When it is undefined, reads return only the stored contents.
//
// Parameters:
//   BITSIZE  data width of each register
//   ADDSIZE  address width (depth = 2**ADDSIZE)
//   NRD      number of read ports (1..8)
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   ra             read addresses, port k at [k*ADDSIZE +: ADDSIZE]
//   adat           read data,      port k at [k*BITSIZE +: BITSIZE]
//   rdy            rdy[k]=1 when the register read by port k is not busy
//   rw0/wdat0/wren0  write port 0
//   rw1/wdat1/wren1  write port 1 (higher priority)
//   rsv/rsv_en     destination reservation
//   busy_cnt       number of busy registers (0..2**ADDSIZE)
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int BITSIZE = 16,
  parameter int ADDSIZE = 4,
  parameter int NRD     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*ADDSIZE-1:0] ra,
  output logic [NRD*BITSIZE-1:0] adat,
  output logic [NRD-1:0]         rdy,
  input  logic [ADDSIZE-1:0]     rw0,
  input  logic [BITSIZE-1:0]     wdat0,
  input  logic                   wren0,
  input  logic [ADDSIZE-1:0]     rw1,
  input  logic [BITSIZE-1:0]     wdat1,
  input  logic                   wren1,
  input  logic [ADDSIZE-1:0]     rsv,
  input  logic                   rsv_en,
  output logic [ADDSIZE:0]       busy_cnt
);

  localparam int DEPTH = 1 << ADDSIZE;

  logic [BITSIZE-1:0] regs [DEPTH];
  logic [DEPTH-1:0]   busy;
  logic [DEPTH-1:0]   set_vec;
  logic [DEPTH-1:0]   clr_vec;
  logic [DEPTH-1:0]   busy_nxt;
  logic               cnt_inc;
  logic               cnt_dec0;
  logic               cnt_dec1;

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage is reset in flops on purpose, because every register has
  // to read back 0 immediately after reset. For that reason it cannot be
  // mapped to a RAM macro that has no reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        // Port 1 is tested first, so on an address collision port 0 is dropped.
        if (wren1 && rw1 == ADDSIZE'(r))      regs[r] <= wdat1;
        else if (wren0 && rw0 == ADDSIZE'(r)) regs[r] <= wdat0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in this block is given a default first. If
  // any path left one unassigned, a latch would be inferred.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (rsv_en) set_vec[rsv] = 1'b1;
    if (wren0)  clr_vec[rw0] = 1'b1;
    if (wren1)  clr_vec[rw1] = 1'b1;
    // The reservation overrides a write-back to the same register.
    busy_nxt = set_vec | (busy & ~clr_vec);
  end

  // Only the reserved register can rise. Each write port can drop at most one
  // register. When both ports hit the same register, port 1 alone accounts
  // for the drop, so it is not counted twice.
  assign cnt_inc  = rsv_en & ~busy[rsv];
  assign cnt_dec0 = wren0 & busy[rw0] & ~set_vec[rw0] & ~(wren1 && rw1 == rw0);
  assign cnt_dec1 = wren1 & busy[rw1] & ~set_vec[rw1];

  // NOTE: state registers use non-blocking assignments. All flops then sample
  // pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + (ADDSIZE+1)'(cnt_inc)
                           - (ADDSIZE+1)'(cnt_dec0)
                           - (ADDSIZE+1)'(cnt_dec1);
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDSIZE-1:0] a;
    assign a = ra[k*ADDSIZE +: ADDSIZE];

`ifdef REGFILE_BYPASS_EN
    logic hit0;
    logic hit1;
    // Forwarding is gated by rst, so reads during reset show the cleared file.
    assign hit1 = rst & wren1 & (rw1 == a);
    assign hit0 = rst & wren0 & (rw0 == a);

    assign adat[k*BITSIZE +: BITSIZE] = hit1 ? wdat1 :
                                        hit0 ? wdat0 : regs[a];
    // A write-back this cycle frees the register early, unless a new producer
    // reserves it in the same cycle.
    assign rdy[k] = ~busy[a] | ((hit0 | hit1) & ~(rsv_en && rsv == a));
`else
    assign adat[k*BITSIZE +: BITSIZE] = regs[a];
    assign rdy[k]                     = ~busy[a];
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Self-checking bench for regfile_scoreboard (BITSIZE=16, ADDSIZE=4, NRD=2).
// A behavioural model made of arrays is updated at every rising edge and
// cleared on reset. One compare process checks adat, rdy and busy_cnt against
// that model on every falling edge. Directed scenarios pin known literal
// values, and a randomized phase follows them. Compile with
// +define+REGFILE_BYPASS_EN to check the forwarding build.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ra;
  logic [31:0] adat;
  logic [1:0]  rdy;
  logic [3:0]  rw0, rw1, rsv;
  logic [15:0] wdat0, wdat1;
  logic        wren0, wren1, rsv_en;
  logic [4:0]  busy_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  regfile_scoreboard #(.BITSIZE(16), .ADDSIZE(4), .NRD(2)) dut (
    .clk(clk), .rst(rst), .ra(ra), .adat(adat), .rdy(rdy),
    .rw0(rw0), .wdat0(wdat0), .wren0(wren0),
    .rw1(rw1), .wdat1(wdat1), .wren1(wren1),
    .rsv(rsv), .rsv_en(rsv_en), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [15:0] m_reg  [16];
  bit          m_busy [16];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 16; r++) begin
        m_reg[r]  = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      // Port 1 is applied last, so it wins a collision.
      if (wren0) m_reg[rw0] = wdat0;
      if (wren1) m_reg[rw1] = wdat1;
      for (int r = 0; r < 16; r++) begin
        if (rsv_en && rsv == r)                                 m_busy[r] = 1'b1;
        else if ((wren0 && rw0 == r) || (wren1 && rw1 == r))    m_busy[r] = 1'b0;
      end
    end
  end

  // Single compare process, run at the falling edge away from state updates.
  always @(negedge clk) begin
    logic [31:0] e_adat;
    logic [1:0]  e_rdy;
    int          cnt;
    int          a;
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        a = int'(ra[k*4 +: 4]);
        e_adat[k*16 +: 16] = m_reg[a];
        e_rdy[k]           = !m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (rst === 1'b1) begin
          if (wren1 && rw1 == a)      e_adat[k*16 +: 16] = wdat1;
          else if (wren0 && rw0 == a) e_adat[k*16 +: 16] = wdat0;
          if (((wren0 && rw0 == a) || (wren1 && rw1 == a)) && !(rsv_en && rsv == a))
            e_rdy[k] = 1'b1;
        end
`endif
      end
      cnt = 0;
      for (int r = 0; r < 16; r++) cnt += int'(m_busy[r]);
      check("cmp_adat", adat, e_adat);
      check("cmp_rdy", {30'b0, rdy}, {30'b0, e_rdy});
      check("cmp_busy_cnt", {27'b0, busy_cnt}, cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle();
    wren0 = 1'b0; wren1 = 1'b0; rsv_en = 1'b0;
  endtask

  // Returns 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ra = '0; rw0 = '0; rw1 = '0; rsv = '0;
    wdat0 = '0; wdat1 = '0;
    idle();

    // 1. Reset and readback.
    #12 rst = 1'b1;
    cmp_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      ra = {4'(a), 4'(a)};
      #1;
      check("reset_adat", adat, 32'h0);
      check("reset_rdy", {30'b0, rdy}, 32'h3);
      check("reset_cnt", {27'b0, busy_cnt}, 32'h0);
    end

    // 2. Write-port collision, then independent writes.
    step();
    wren0 = 1'b1; rw0 = 4'd5; wdat0 = 16'h1111;
    wren1 = 1'b1; rw1 = 4'd5; wdat1 = 16'h2222;
    step(); idle(); ra = {4'd5, 4'd5}; #1;
    check("collision_port1_wins", {16'b0, adat[15:0]}, 32'h2222);
    wren0 = 1'b1; rw0 = 4'd3; wdat0 = 16'hA5A5;
    wren1 = 1'b1; rw1 = 4'd9; wdat1 = 16'h5A5A;
    step(); idle(); ra = {4'd9, 4'd3}; #1;
    check("dual_write", adat, 32'h5A5A_A5A5);

    // 3. Scoreboard: reserve, write back, reserve+write together.
    rsv_en = 1'b1; rsv = 4'd7;
    step(); idle(); ra = {4'd7, 4'd7}; #1;
    check("rsv7_rdy", {30'b0, rdy}, 32'h0);
    check("rsv7_cnt", {27'b0, busy_cnt}, 32'd1);
    wren0 = 1'b1; rw0 = 4'd7; wdat0 = 16'h00FF;
    step(); idle(); #1;
    check("wb7_rdy", {30'b0, rdy}, 32'h3);
    check("wb7_cnt", {27'b0, busy_cnt}, 32'd0);
    check("wb7_data", {16'b0, adat[15:0]}, 32'h00FF);
    rsv_en = 1'b1; rsv = 4'd7; wren0 = 1'b1; rw0 = 4'd7; wdat0 = 16'h0ABC;
    step(); idle(); #1;
    check("rsv_wb7_rdy", {30'b0, rdy}, 32'h0);
    check("rsv_wb7_cnt", {27'b0, busy_cnt}, 32'd1);
    wren0 = 1'b1; rw0 = 4'd7;
    step(); idle(); #1;
    check("drain7_cnt", {27'b0, busy_cnt}, 32'd0);

    // 4. Full occupancy and a two-per-cycle drain.
    for (int r = 0; r < 16; r++) begin
      rsv_en = 1'b1; rsv = 4'(r);
      step();
    end
    idle(); #1;
    check("full_cnt", {27'b0, busy_cnt}, 32'd16);
    for (int i = 0; i < 8; i++) begin
      wren0 = 1'b1; rw0 = 4'(2*i);   wdat0 = 16'(i);
      wren1 = 1'b1; rw1 = 4'(2*i+1); wdat1 = 16'(i + 100);
      step(); idle(); #1;
      check("drain_cnt", {27'b0, busy_cnt}, 32'(16 - 2*(i+1)));
    end

    // 5. Asynchronous reset between edges.
    rsv_en = 1'b1; rsv = 4'd1; wren0 = 1'b1; rw0 = 4'd2; wdat0 = 16'hBEEF;
    step(); wren0 = 1'b0; rsv = 4'd2;
    step(); rsv = 4'd3;
    step(); rsv = 4'd4;
    step(); idle(); ra = {4'd2, 4'd2}; #1;
    check("pre_rst_cnt", {27'b0, busy_cnt}, 32'd4);
    check("pre_rst_data", {16'b0, adat[15:0]}, 32'hBEEF);
    #2 rst = 1'b0;
    #1;
    check("async_rst_adat", adat, 32'h0);
    check("async_rst_cnt", {27'b0, busy_cnt}, 32'd0);
    check("async_rst_rdy", {30'b0, rdy}, 32'h3);
    #2 rst = 1'b1;

    // 6. Same-cycle read of a register being written.
    step();
    ra = {4'd4, 4'd4};
    wren1 = 1'b1; rw1 = 4'd4; wdat1 = 16'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", {16'b0, adat[15:0]}, 32'h1234);
`else
    check("no_bypass_same_cycle", {16'b0, adat[15:0]}, 32'h0000);
`endif
    step(); idle(); #1;
    check("after_edge_4", {16'b0, adat[15:0]}, 32'h1234);

    // Randomized phase with occasional mid-cycle reset pulses.
    for (int c = 0; c < 400; c++) begin
      step();
      ra     = 8'($urandom);
      rw0    = 4'($urandom_range(0, 15));
      rw1    = ($urandom_range(0, 3) == 0) ? rw0 : 4'($urandom_range(0, 15));
      rsv    = ($urandom_range(0, 3) == 0) ? rw1 : 4'($urandom_range(0, 15));
      wdat0  = 16'($urandom);
      wdat1  = 16'($urandom);
      wren0  = ($urandom_range(0, 9) < 4);
      wren1  = ($urandom_range(0, 9) < 4);
      rsv_en = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b0;
        #3 rst = 1'b1;
      end
    end

    step(); idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the two-read/one-write register file, intended for the pipelined MIPS datapath.
- Provides NRD read ports and two write ports with fixed priority.
- Each register carries a busy bit: set when a later stage reserves that register as a destination, cleared when it is written back. Issue logic uses the busy bits to stall on RAW hazards.
- Also reports a running count of busy registers.

Parameters:
- BITSIZE, 16, data width of each register
- ADDSIZE, 4, address width; depth = 2**ADDSIZE
- NRD, 2, number of read ports (1..8)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- ra  in  NRD*ADDSIZE  read addresses; port k uses bits [k*ADDSIZE +: ADDSIZE]
- adat  out  NRD*BITSIZE  read data; port k uses bits [k*BITSIZE +: BITSIZE]
- rdy  out  NRD  rdy[k]=1 when the register addressed by port k is not busy
- rw0  in  ADDSIZE  write port 0 address
- wdat0  in  BITSIZE  write port 0 data
- wren0  in  1  write port 0 enable
- rw1  in  ADDSIZE  write port 1 address
- wdat1  in  BITSIZE  write port 1 data
- wren1  in  1  write port 1 enable
- rsv  in  ADDSIZE  register to reserve
- rsv_en  in  1  reserve enable
- busy_cnt  out  ADDSIZE+1  number of busy registers

Behaviour:
- Reset (rst=0), asynchronous:
  - all registers := 0; all busy bits := 0; busy_cnt := 0.
  - While reset is held, adat reads 0 and rdy is all ones.
  - Reset asserted mid-operation takes effect immediately, with no clock edge required.
  - Writes and reservations at an edge where rst=0 are discarded.
- Reads:
  - Combinational, zero latency: adat[k] = reg[ra[k]].
  - rdy[k] = ~busy[ra[k]].
- Writes, on posedge:
  - wren0 writes wdat0 to reg[rw0]; wren1 writes wdat1 to reg[rw1].
  - Both enabled with rw0==rw1: port 1 wins. Port 0's write to that address is dropped.
  - A write takes effect at the edge. A read in the same cycle returns the old value unless bypass is enabled (see Optional Feature).
- Busy bits, per register r, evaluated at posedge:
  - set = rsv_en && rsv==r
  - clr = (wren0 && rw0==r) || (wren1 && rw1==r)
  - set has priority: busy[r] := set ? 1 : (clr ? 0 : busy[r]). Reserving and writing the same register in one cycle models a new producer overtaking the old one, so the register stays busy.
  - Reserving an already-busy register leaves it busy; the count does not change.
  - Writing a non-busy register is legal; busy stays 0.
- busy_cnt:
  - Registered; always equals the popcount of the busy vector after each edge.
  - Updated incrementally as +1 for a 0->1 transition, -1 for each 1->0 transition (up to two per cycle).
  - Range 0..2**ADDSIZE, so full occupancy (all 16 registers busy) = 16 and does not wrap.
- Addresses are always in range; there is no out-of-range handling.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined (write-first forwarding):
  - If wren1 && rw1==ra[k], adat[k]=wdat1.
  - Else if wren0 && rw0==ra[k], adat[k]=wdat0.
  - Else adat[k]=reg[ra[k]].
  - rdy[k] is also 1 when a write port targets ra[k] this cycle, unless rsv_en && rsv==ra[k].
  - Forwarding is suppressed while rst=0.
- Not defined: reads return stored contents only; rdy = ~busy; no combinational path from wdat to adat.

Test Plan:
1. Reset and readback: hold rst=0 for 10 ns, release. Read all 16 addresses on both ports -> adat=0, rdy=2'b11, busy_cnt=0.
2. Write-port collision: rw0=rw1=5, wdat0=16'h1111, wdat1=16'h2222, wren0=wren1=1 for one edge -> reg5 reads 16'h2222. Separately write 16'hA5A5 to reg 3 via port 0 and 16'h5A5A to reg 9 via port 1 in one cycle -> both read back correctly on ports 0 and 1.
3. Scoreboard: reserve reg 7 -> rdy=0 when ra=7, busy_cnt=1. Next edge write reg 7=16'h00FF -> rdy=1, busy_cnt=0. Reserve and write reg 7 in the same cycle -> stays busy, busy_cnt=1.
4. Full occupancy: reserve regs 0..15 on consecutive edges -> busy_cnt reaches 16 (5'b10000). Then write two registers per cycle over 8 cycles -> busy_cnt decrements by 2 each edge to 0.
5. Async reset mid-operation: with busy_cnt=4 and reg2=16'hBEEF, drive rst=0 between clock edges -> adat=0, busy_cnt=0, rdy all ones before the next edge.
6. Bypass (run twice, macro on and off): ra0=4, write reg4=16'h1234 with wren1=1. With REGFILE_BYPASS_EN, adat0=16'h1234 in the same cycle. Without it, adat0 shows the old value until after the edge.
